// File: rtl/vga_timing_ctrl_if.sv
// Frame-source request/data bus plus the VGA pin group driven by vga_timing_ctrl.
interface vga_timing_ctrl_if;
  logic        pattern_en;
  logic [23:0] vga_data;
  logic        pix_req;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        frame_start;
  logic        VGA_CLK;
  logic        VGA_HSYNC;
  logic        VGA_VSYNC;
  logic        VGA_BLANK_N;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;

  modport master (
    input  pattern_en, vga_data,
    output pix_req, h_addr, v_addr, frame_start,
    output VGA_CLK, VGA_HSYNC, VGA_VSYNC, VGA_BLANK_N, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    output pattern_en, vga_data,
    input  pix_req, h_addr, v_addr, frame_start,
    input  VGA_CLK, VGA_HSYNC, VGA_VSYNC, VGA_BLANK_N, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel prescaler, h/v counters, pixel requests and a
// two-tick output pipeline so returned pixel data lines up with the syncs.
module vga_timing_ctrl #(
  parameter int CLK_DIV = 1,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10
) (
  input  logic clk,
  input  logic rst,
  vga_timing_ctrl_if.master bus
);

  localparam int H_TOTAL   = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL   = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int H_ACT_BEG = H_SYNC + H_BP;
  localparam int V_ACT_BEG = V_SYNC + V_BP;
  localparam int BAR_W     = H_ACT / 8;
  localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_reg;
  logic             tick;
  logic [9:0]       h_cnt_reg;
  logic [9:0]       v_cnt_reg;
  logic             h_last;
  logic             v_last;
  logic             frame_start_reg;

  logic             h_in;
  logic             v_in;
  logic             act;
  logic             hs0;
  logic             vs0;
  logic [9:0]       h_addr_s0;
  logic [9:0]       v_addr_s0;

  logic             act_d_reg;
  logic             hs_d_reg;
  logic             vs_d_reg;
  logic [9:0]       h_addr_d_reg;
  logic [6:0]       bar_ge;
  logic [2:0]       bar_idx;
  logic [23:0]      rgb_next;

  logic             hsync_reg;
  logic             vsync_reg;
  logic             blank_n_reg;
  logic [23:0]      rgb_reg;

  assign tick = (div_cnt_reg == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt_reg <= '0;
    end else if (tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  generate
    if (CLK_DIV == 1) begin : g_clk_direct
      assign bus.VGA_CLK = clk;
    end else begin : g_clk_div
      assign bus.VGA_CLK = (div_cnt_reg >= DIV_W'(CLK_DIV / 2));
    end
  endgenerate

  assign h_last = (h_cnt_reg == 10'(H_TOTAL - 1));
  assign v_last = (v_cnt_reg == 10'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      h_cnt_reg       <= '0;
      v_cnt_reg       <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      // Qualified by tick so the pulse stays one clk wide at any divider.
      frame_start_reg <= tick && h_last && v_last;
      if (tick) begin
        if (h_last) begin
          h_cnt_reg <= '0;
          v_cnt_reg <= v_last ? 10'd0 : v_cnt_reg + 10'd1;
        end else begin
          h_cnt_reg <= h_cnt_reg + 10'd1;
        end
      end
    end
  end

  assign h_in      = (h_cnt_reg >= 10'(H_ACT_BEG)) && (h_cnt_reg < 10'(H_ACT_BEG + H_ACT));
  assign v_in      = (v_cnt_reg >= 10'(V_ACT_BEG)) && (v_cnt_reg < 10'(V_ACT_BEG + V_ACT));
  assign act       = h_in && v_in;
  assign hs0       = (h_cnt_reg < 10'(H_SYNC));
  assign vs0       = (v_cnt_reg < 10'(V_SYNC));
  assign h_addr_s0 = act ? (h_cnt_reg - 10'(H_ACT_BEG)) : 10'd0;
  assign v_addr_s0 = act ? (v_cnt_reg - 10'(V_ACT_BEG)) : 10'd0;

  // Bar index as a thermometer of column thresholds, avoiding a divider.
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_bar
      assign bar_ge[gi-1] = (h_addr_d_reg >= 10'(gi * BAR_W));
    end
  endgenerate

  always_comb begin
    bar_idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      bar_idx = bar_idx + 3'(bar_ge[i]);
    end
  end

  always_comb begin
    rgb_next = 24'h0;
    if (act_d_reg) begin
      rgb_next = bus.pattern_en ? {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}}
                                : bus.vga_data;
    end
  end

  // The _d stage covers the frame source's one-tick read latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      act_d_reg    <= 1'b0;
      hs_d_reg     <= 1'b0;
      vs_d_reg     <= 1'b0;
      h_addr_d_reg <= '0;
      hsync_reg    <= 1'b1;
      vsync_reg    <= 1'b1;
      blank_n_reg  <= 1'b0;
      rgb_reg      <= '0;
    end else if (tick) begin
      act_d_reg    <= act;
      hs_d_reg     <= hs0;
      vs_d_reg     <= vs0;
      h_addr_d_reg <= h_addr_s0;
      hsync_reg    <= ~hs_d_reg;
      vsync_reg    <= ~vs_d_reg;
      blank_n_reg  <= act_d_reg;
      rgb_reg      <= rgb_next;
    end
  end

  assign bus.pix_req     = act;
  assign bus.h_addr      = h_addr_s0;
  assign bus.v_addr      = v_addr_s0;
  assign bus.frame_start = frame_start_reg;
  assign bus.VGA_HSYNC   = hsync_reg;
  assign bus.VGA_VSYNC   = vsync_reg;
  assign bus.VGA_BLANK_N = blank_n_reg;
  assign bus.VGA_R       = rgb_reg[23:16];
  assign bus.VGA_G       = rgb_reg[15:8];
  assign bus.VGA_B       = rgb_reg[7:0];

endmodule
